// File: rtl/add_round_key_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | add_round_key_stream: column-serial AES-128 AddRoundKey with shadowed key.   |
// | Optional macro ADDKEY_BYPASS_EN adds a per-column bypass input.              |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module add_round_key_stream #(
   parameter  int COL_W    = 32,
   parameter  int NUM_COLS = 4,
   localparam int KEY_W    = COL_W * NUM_COLS,
   localparam int CNT_W    = $clog2(NUM_COLS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               key_load,
   input  logic [KEY_W-1:0]   key_in,
   output logic               key_valid,
   output logic               key_pending,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COL_W-1:0]   in_data,
`ifdef ADDKEY_BYPASS_EN
   input  logic               bypass,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COL_W-1:0]   out_data,
   output logic [CNT_W-1:0]   out_col,
   output logic               out_last
);

   localparam logic [CNT_W-1:0] c_LAST_COL = CNT_W'(NUM_COLS - 1);

   logic [KEY_W-1:0] r_key;
   logic [KEY_W-1:0] r_shadow;
   logic             r_key_valid;
   logic             r_key_pending;
   logic [CNT_W-1:0] r_col_cnt;
   logic             r_out_valid;
   logic [COL_W-1:0] r_out_data;
   logic [CNT_W-1:0] r_out_col;
   logic             r_out_last;

   logic             w_in_ready;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_boundary;
   logic             w_wrap;
   logic [COL_W-1:0] w_key_col;
   logic [COL_W-1:0] w_col_data;

   assign w_in_ready = r_key_valid && (!r_out_valid || out_ready);
   assign w_in_xfer  = in_valid && w_in_ready;
   assign w_out_xfer = r_out_valid && out_ready;
   assign w_boundary = (r_col_cnt == '0);
   assign w_wrap     = w_in_xfer && (r_col_cnt == c_LAST_COL);

   // Column 0 of the key lives in the most significant bits.
   always_comb begin
      w_key_col = '0;
      for (int i = 0; i < NUM_COLS; i++) begin
         if (r_col_cnt == CNT_W'(i)) begin
            w_key_col = r_key[KEY_W-1-i*COL_W -: COL_W];
         end
      end
   end

`ifdef ADDKEY_BYPASS_EN
   assign w_col_data = bypass ? in_data : (in_data ^ w_key_col);
`else
   assign w_col_data = in_data ^ w_key_col;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_key         <= '0;
         r_shadow      <= '0;
         r_key_valid   <= 1'b0;
         r_key_pending <= 1'b0;
      end else if (key_load) begin
         // Direct load only when no column is using the key this cycle or the
         // block is closing; otherwise hold it until the next boundary.
         if ((w_boundary && !w_in_xfer) || w_wrap) begin
            r_key         <= key_in;
            r_key_valid   <= 1'b1;
            r_key_pending <= 1'b0;
         end else begin
            r_shadow      <= key_in;
            r_key_pending <= 1'b1;
         end
      end else if (w_wrap && r_key_pending) begin
         r_key         <= r_shadow;
         r_key_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_col_cnt   <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_col   <= '0;
         r_out_last  <= 1'b0;
      end else if (w_in_xfer) begin
         r_col_cnt   <= w_wrap ? '0 : r_col_cnt + 1'b1;
         r_out_valid <= 1'b1;
         r_out_data  <= w_col_data;
         r_out_col   <= r_col_cnt;
         r_out_last  <= (r_col_cnt == c_LAST_COL);
      end else if (w_out_xfer) begin
         r_out_valid <= 1'b0;
      end
   end

   assign key_valid   = r_key_valid;
   assign key_pending = r_key_pending;
   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_col     = r_out_col;
   assign out_last    = r_out_last;

endmodule
`default_nettype wire
